// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to add req_last and per-requester message locking.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   req_last,
`endif
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 busy
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_reg;
   logic [7:0]         tx_data_reg;
   logic               tx_valid_reg;
   logic [IDX_W-1:0]   grant_id_reg;
   logic               busy_reg;
   logic [IDX_W-1:0]   rr_ptr_reg;
   logic               lock_reg;

   logic [NUM_REQ-1:0]   elig;
   logic [2*NUM_REQ-1:0] elig_dbl;
   logic [NUM_REQ-1:0]   elig_rot;
   logic                 win_found;
   int                   win_pos;
   int                   win_sum;
   logic [IDX_W-1:0]     win_idx;
   logic [7:0]           win_byte;
   logic                 win_last;
   logic [IDX_W-1:0]     ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
`ifdef UART_ARB_LOCK_EN
         // While locked only the requester holding the lock (last grant) may compete.
         assign elig[gi] = req_valid[gi] & (~lock_reg | (grant_id_reg == IDX_W'(gi)));
`else
         assign elig[gi] = req_valid[gi];
`endif
         assign req_ready[gi] = (state_reg == IDLE) & win_found & (win_idx == IDX_W'(gi));
      end
   endgenerate

`ifndef UART_ARB_LOCK_EN
   assign lock_reg = 1'b0;
`endif

   // Rotate the eligible vector so bit 0 is rr_ptr; the lowest set bit wins.
   always_comb begin
      elig_dbl  = {elig, elig} >> rr_ptr_reg;
      elig_rot  = elig_dbl[NUM_REQ-1:0];
      win_found = 1'b0;
      win_pos   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (elig_rot[k]) begin
            win_found = 1'b1;
            win_pos   = k;
         end
      end
      win_sum = int'(rr_ptr_reg) + win_pos;
      if (win_sum >= NUM_REQ) begin
         win_sum = win_sum - NUM_REQ;
      end
      win_idx  = IDX_W'(win_sum);
      win_byte = '0;
      win_last = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_byte = req_data[8*i +: 8];
`ifdef UART_ARB_LOCK_EN
            win_last = req_last[i];
`endif
         end
      end
      ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         grant_id_reg <= '0;
         busy_reg     <= 1'b0;
         rr_ptr_reg   <= '0;
`ifdef UART_ARB_LOCK_EN
         lock_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  tx_data_reg  <= win_byte;
                  tx_valid_reg <= 1'b1;
                  grant_id_reg <= win_idx;
                  busy_reg     <= 1'b1;
                  rr_ptr_reg   <= ptr_next;
                  state_reg    <= SEND;
`ifdef UART_ARB_LOCK_EN
                  lock_reg     <= ~win_last;
`endif
               end
            end
            SEND: begin
               if (tx_ready) begin
                  tx_valid_reg <= 1'b0;
                  busy_reg     <= 1'b0;
                  state_reg    <= IDLE;
               end
            end
         endcase
      end
   end

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
   assign grant_id = grant_id_reg;
   assign busy     = busy_reg;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single on-chip UART transmitter among NUM_REQ byte producers, e.g. CPU store path at 0x80000008, hardware trace/status dumper, debug monitor.
- Round-robin grant per byte; accepted byte is registered and presented to the UART data_in/data_in_valid/data_in_ready handshake.
- Sits between the requesters and the uart instance in the IO memory map.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- IDX_W, 2, width of grant index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- req_valid  input  NUM_REQ  requester i has a byte.
- req_ready  output  NUM_REQ  one-hot; byte i accepted this cycle when req_valid[i] & req_ready[i].
- tx_data  output  8  to uart data_in.
- tx_valid  output  1  to uart data_in_valid.
- tx_ready  input  1  from uart data_in_ready.
- grant_id  output  IDX_W  index of requester whose byte is in tx_data.
- busy  output  1  high while in SEND.

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, tx_valid=0, tx_data=0, grant_id=0, busy=0, rr_ptr=0, req_ready=0. Lock state cleared when the optional feature is compiled in.
- States: IDLE, SEND.
- IDLE:
  - If no req_valid bit is set: req_ready=0 and the block stays in IDLE.
  - Otherwise winner g = first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot(g), combinational from req_valid and state. Requesters must not make req_valid depend on req_ready.
  - On that edge: tx_data<=byte g, tx_valid<=1, grant_id<=g, busy<=1, rr_ptr<=(g+1) mod NUM_REQ, state<=SEND.
- SEND:
  - req_ready=0 for all requesters; tx_data and grant_id are held stable.
  - On an edge with tx_ready=1: tx_valid<=0, busy<=0, state<=IDLE.
  - Otherwise remain in SEND.
- Latency: byte accepted at edge N; tx_valid is visible from N to N+1.
- Throughput: at most one byte per 2 cycles. tx_valid drops for at least one cycle between bytes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 bytes.
- Wrap-around: rr_ptr increments modulo NUM_REQ, never ≥ NUM_REQ. With NUM_REQ=3 and IDX_W=2, value 3 is unreachable.
- Simultaneous events:
  - A req_valid rising during SEND is not accepted until the next IDLE cycle.
  - tx_ready and a new req_valid in the same SEND cycle: return to IDLE first, no bypass.
- A requester deasserting req_valid while not granted is legal; no byte is consumed.
- Reset mid-SEND: the pending byte is discarded, tx_valid=0 after the reset edge, and rr_ptr returns to 0.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- Defined:
  - Adds input req_last (NUM_REQ wide), sampled with the accepted byte.
  - If the accepted byte has req_last[g]=0, the arbiter locks to g. In subsequent IDLE cycles only requester g is eligible; others see req_ready=0 even when g is not valid.
  - Lock releases when a byte from g is accepted with req_last[g]=1. rr_ptr still updates to g+1 on every grant.
  - Reset clears the lock.
- Undefined: the req_last port does not exist and every byte is arbitrated independently.

Test Plan:
- Single requester: req_valid=01, req_data[7:0]=0x41, tx_ready held 0 for 5 cycles then 1 -> req_ready=01 for exactly one cycle; tx_data=0x41, grant_id=0, tx_valid high 6 cycles, then low; busy mirrors tx_valid.
- Contention: both valid continuously, bytes 0xA0.. (req0) and 0xB0.. (req1), tx_ready=1 always -> UART sees 0xA0,0xB0,0xA1,0xB1; a new tx_valid pulse every 2 cycles.
- Rotation start: after reset, only req1 valid with 0x55 and it is sent; then both valid -> next grant goes to req0 (rr_ptr=0 after wrap).
- Back-pressure: req0 valid during SEND of a req1 byte with tx_ready=0 -> req_ready stays 00 until tx_ready handshake; req0 is accepted on the following IDLE cycle.
- Reset mid-send: rst asserted one cycle during SEND of 0x7E -> tx_valid=0, busy=0, grant_id=0 after the edge; the byte is never re-presented.
- Lock (UART_ARB_LOCK_EN defined): req0 sends 0x10,0x11,0x12 with last on 0x12 while req1 is continuously valid -> UART order is 0x10,0x11,0x12, then the req1 byte.
